// File: rtl/mult_sequencer.sv
// Unsigned 8x8 shift-and-add multiplier. It sequences the Decoder one instruction
// per clock and registers ALUBus into Product after READ. Busy spans 3+6*ITERATIONS+2 cycles.
module mult_sequencer #(
  parameter int ITERATIONS = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic [4:0]  Flags,
  input  logic [15:0] ALUBus,
  output logic [15:0] Instruction,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Product
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_CLR  = 4'd1;
  localparam logic [3:0] S_LDA  = 4'd2;
  localparam logic [3:0] S_LDB  = 4'd3;
  localparam logic [3:0] S_COPY = 4'd4;
  localparam logic [3:0] S_MASK = 4'd5;
  localparam logic [3:0] S_TEST = 4'd6;
  localparam logic [3:0] S_ACC  = 4'd7;
  localparam logic [3:0] S_SHL  = 4'd8;
  localparam logic [3:0] S_SHR  = 4'd9;
  localparam logic [3:0] S_READ = 4'd10;
  localparam logic [3:0] S_CAPT = 4'd11;

  localparam logic [15:0] I_NOP  = 16'h0000;
  localparam logic [15:0] I_CLR  = 16'hD300;
  localparam logic [15:0] I_COPY = 16'h02D1;
  localparam logic [15:0] I_MASK = 16'h1201;
  localparam logic [15:0] I_TEST = 16'h02D2;
  localparam logic [15:0] I_ADD  = 16'h0350;
  localparam logic [15:0] I_SHL  = 16'h8041;
  localparam logic [15:0] I_SHR  = 16'h814F;
  localparam logic [15:0] I_READ = 16'h03D3;

  localparam logic [2:0] LAST_ITER = 3'(ITERATIONS - 1);

  logic [3:0]  state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] product_q, product_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;

  logic unused_flags;
  assign unused_flags = ^Flags[3:0];

  always_comb begin
    state_d   = state_q;
    instr_d   = I_NOP;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_CLR;
          instr_d = I_CLR;
          busy_d  = 1'b1;
          cnt_d   = 3'd0;
          a_d     = A;
          b_d     = B;
        end
      end
      S_CLR: begin
        state_d = S_LDA;
        instr_d = {8'hD0, a_q};
      end
      S_LDA: begin
        state_d = S_LDB;
        instr_d = {8'hD1, b_q};
      end
      S_LDB: begin
        state_d = S_COPY;
        instr_d = I_COPY;
      end
      S_COPY: begin
        state_d = S_MASK;
        instr_d = I_MASK;
      end
      S_MASK: begin
        state_d = S_TEST;
        instr_d = I_TEST;
      end
      // The ACC word is registered on the edge that enters ACC. The zero flag
      // seen then comes from MASK, and TEST leaves the same R2 value.
      S_TEST: begin
        state_d = S_ACC;
        instr_d = Flags[4] ? I_TEST : I_ADD;
      end
      S_ACC: begin
        state_d = S_SHL;
        instr_d = I_SHL;
      end
      S_SHL: begin
        state_d = S_SHR;
        instr_d = I_SHR;
      end
      S_SHR: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_READ;
          instr_d = I_READ;
        end else begin
          state_d = S_COPY;
          instr_d = I_COPY;
        end
      end
      S_READ: begin
        state_d = S_CAPT;
      end
      S_CAPT: begin
        state_d   = S_IDLE;
        product_d = ALUBus;
        done_d    = 1'b1;
        busy_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      instr_q   <= I_NOP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= 16'h0000;
      cnt_q     <= 3'd0;
      a_q       <= 8'h00;
      b_q       <= 8'h00;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

  assign Instruction = instr_q;
  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Product     = product_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: a behavioural Decoder, an expected-result scoreboard and
// an independent monitor that checks the instruction trace, Product and timing.
module tb_mult_sequencer;

  localparam int ITER      = 8;
  localparam int TRACE_LEN = 3 + 6 * ITER + 2;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [4:0]  flags_m;
  logic [15:0] alu_m;
  logic [15:0] Instruction;
  logic        Busy;
  logic        Done;
  logic [15:0] Product;

  mult_sequencer #(.ITERATIONS(ITER)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .A(A),
    .B(B),
    .Flags(flags_m),
    .ALUBus(alu_m),
    .Instruction(Instruction),
    .Busy(Busy),
    .Done(Done),
    .Product(Product)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural Decoder executing the word on Instruction at each rising edge.
  logic [15:0] rf [4];
  logic [15:0] dec_res;
  logic        dec_wr;
  logic [1:0]  dec_rd;
  int          dec_sh;

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 16'h0000;
    alu_m   = 16'h0000;
    flags_m = 5'b00000;
  end

  always_comb begin
    dec_wr  = 1'b0;
    dec_res = 16'h0000;
    dec_rd  = Instruction[9:8];
    dec_sh  = 0;
    case (Instruction[15:12])
      4'hD: begin
        dec_wr  = 1'b1;
        dec_res = {8'h00, Instruction[7:0]};
      end
      4'h1: begin
        dec_wr  = 1'b1;
        dec_res = rf[dec_rd] & {8'h00, Instruction[7:0]};
      end
      4'h8: begin
        dec_wr = 1'b1;
        dec_sh = int'($signed(Instruction[3:0]));
        if (dec_sh > 0) dec_res = rf[dec_rd] << dec_sh;
        else            dec_res = rf[dec_rd] >> (-dec_sh);
      end
      4'h0: begin
        if (Instruction[7:4] == 4'hD) begin
          dec_wr  = 1'b1;
          dec_res = rf[Instruction[1:0]];
        end else if (Instruction[7:4] == 4'h5) begin
          dec_wr  = 1'b1;
          dec_res = rf[dec_rd] + rf[Instruction[1:0]];
        end
      end
      default: dec_wr = 1'b0;
    endcase
  end

  always @(posedge Clock) begin
    if (dec_wr) begin
      rf[dec_rd] <= dec_res;
      alu_m      <= dec_res;
      flags_m    <= {(dec_res == 16'h0000), 4'b0000};
    end
  end

  // Scoreboard
  typedef struct {
    logic [15:0] prod;
    logic [15:0] tr [TRACE_LEN];
  } exp_t;

  exp_t sb [$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.prod  = 16'(a) * 16'(b);
    e.tr[0] = 16'hD300;
    e.tr[1] = {8'hD0, a};
    e.tr[2] = {8'hD1, b};
    for (int i = 0; i < ITER; i++) begin
      e.tr[3 + 6*i]     = 16'h02D1;
      e.tr[3 + 6*i + 1] = 16'h1201;
      e.tr[3 + 6*i + 2] = 16'h02D2;
      e.tr[3 + 6*i + 3] = b[i] ? 16'h0350 : 16'h02D2;
      e.tr[3 + 6*i + 4] = 16'h8041;
      e.tr[3 + 6*i + 5] = 16'h814F;
    end
    e.tr[TRACE_LEN-2] = 16'h03D3;
    e.tr[TRACE_LEN-1] = 16'h0000;
    return e;
  endfunction

  // Monitor
  int   run_len   = 0;
  logic busy_prev = 1'b0;
  logic done_prev = 1'b0;

  initial begin
    forever begin
      @(negedge Clock);
      if (Reset) begin
        sb.delete();
        run_len   = 0;
        busy_prev = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (Busy) begin
          if (!busy_prev) run_len = 0;
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL busy_without_request: Busy=%b with no run outstanding", Busy);
          end else if (run_len < TRACE_LEN) begin
            check($sformatf("instr[%0d]", run_len), {16'h0, Instruction},
                  {16'h0, sb[0].tr[run_len]});
          end
          run_len++;
        end
        if (Done) begin
          check("done_width", {31'h0, done_prev}, 32'd0);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: Product=%h with no run outstanding", Product);
          end else begin
            check("product", {16'h0, Product}, {16'h0, sb[0].prod});
            check("busy_cycles", run_len, TRACE_LEN);
            check("busy_before_done", {31'h0, busy_prev}, 32'd1);
            check("busy_low_at_done", {31'h0, Busy}, 32'd0);
            void'(sb.pop_front());
          end
        end
        busy_prev = Busy;
        done_prev = Done;
      end
    end
  end

  // Stimulus
  task automatic wait_idle();
    int n = 0;
    while (Busy && n < 200) begin
      @(negedge Clock);
      n++;
    end
    if (Busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: Busy=%b after %0d cycles", Busy, n);
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL run_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic start_run(input logic [7:0] a, input logic [7:0] b);
    wait_idle();
    @(negedge Clock);
    A = a;
    B = b;
    Start = 1'b1;
    sb.push_back(mk(a, b));
    @(negedge Clock);
    Start = 1'b0;
    check("busy_rise", {31'h0, Busy}, 32'd1);
  endtask

  task automatic run(input logic [7:0] a, input logic [7:0] b);
    start_run(a, b);
    wait_empty();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"},   {16'h0, Instruction}, 32'h0);
    check({tag, "_busy"},    {31'h0, Busy},        32'h0);
    check({tag, "_done"},    {31'h0, Done},        32'h0);
    check({tag, "_product"}, {16'h0, Product},     32'h0);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    Start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    run(8'h1F, 8'hE3);
    run(8'hFF, 8'hFF);
    run(8'h00, 8'h5A);
    run(8'h03, 8'h02);
    run(8'hFF, 8'h01);

    // Start during a run must not disturb it
    start_run(8'h5C, 8'hA7);
    repeat (19) @(negedge Clock);
    A = 8'h33;
    B = 8'h44;
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    wait_empty();
    repeat (3) @(negedge Clock);

    // Start held high: the second run begins on the first IDLE edge
    wait_idle();
    @(negedge Clock);
    sb.push_back(mk(8'h9D, 8'h6B));
    sb.push_back(mk(8'hC4, 8'h81));
    A = 8'h9D;
    B = 8'h6B;
    Start = 1'b1;
    @(negedge Clock);
    A = 8'hC4;
    B = 8'h81;
    n = 0;
    while (!Done && n < 200) begin
      @(negedge Clock);
      n++;
    end
    check("held_start_done", {31'h0, Done}, 32'd1);
    @(negedge Clock);
    check("held_start_rebusy", {31'h0, Busy}, 32'd1);
    Start = 1'b0;
    wait_empty();

    // Asynchronous reset in the middle of a run
    start_run(8'hB7, 8'hD5);
    repeat (29) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    run(8'h02, 8'h07);

    for (int i = 0; i < 10; i++) begin
      run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(negedge Clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
